// File: rtl/axis_pr_ingress_gate.sv
// AXI4-Stream gate in front of a PR region: packet-aligned decouple, two-entry registered skid buffer; PR_INGRESS_GATE_STATS_EN enables the packet/drop counters.
// Latency: one cycle from S accept to M_AXIS_tvalid; one beat per cycle sustained with M_AXIS_tready high.
// Backpressure: S_AXIS_tready is registered and falls only when both entries will be occupied; while decoupled it stays high and input is discarded.
module axis_pr_ingress_gate #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  ARESETN,
  input  logic                  decouple_req,
  output logic                  decouple_ack,
  input  logic [DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic [KEEP_WIDTH-1:0] S_AXIS_tkeep,
  input  logic                  S_AXIS_tlast,
  input  logic                  S_AXIS_tvalid,
  output logic                  S_AXIS_tready,
  output logic [DATA_WIDTH-1:0] M_AXIS_tdata,
  output logic [KEEP_WIDTH-1:0] M_AXIS_tkeep,
  output logic                  M_AXIS_tlast,
  output logic                  M_AXIS_tvalid,
  input  logic                  M_AXIS_tready,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  typedef enum logic [1:0] {PASS, DRAIN, DECOUPLED} state_t;

  state_t                state, state_n;
  logic                  h_vld, k_vld;
  logic [DATA_WIDTH-1:0] h_dat, k_dat;
  logic [KEEP_WIDTH-1:0] h_keep, k_keep;
  logic                  h_last, k_last;
  logic                  in_pkt, in_pkt_n;
  logic                  s_rdy, ack;
  logic                  s_acc, m_hs, wr;
  logic [1:0]            occ, occ_n;

  assign s_acc    = S_AXIS_tvalid & s_rdy;
  assign m_hs     = h_vld & M_AXIS_tready;
  assign wr       = s_acc & (state != DECOUPLED);
  assign in_pkt_n = s_acc ? ~S_AXIS_tlast : in_pkt;
  assign occ      = {1'b0, h_vld} + {1'b0, k_vld};
  assign occ_n    = occ + {1'b0, wr} - {1'b0, m_hs};

  // Transitions look at the post-accept packet position so a tlast beat this cycle counts as a boundary.
  always_comb begin
    state_n = state;
    case (state)
      PASS:      if (decouple_req) state_n = in_pkt_n ? DRAIN : DECOUPLED;
      DRAIN:     if (!in_pkt_n) state_n = DECOUPLED;
      DECOUPLED: if (!decouple_req && !in_pkt_n) state_n = PASS;
      default:   state_n = PASS;
    endcase
  end

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state  <= PASS;
      in_pkt <= 1'b0;
      s_rdy  <= 1'b0;
      ack    <= 1'b0;
      h_vld  <= 1'b0;
      k_vld  <= 1'b0;
    end else begin
      state  <= state_n;
      in_pkt <= in_pkt_n;
      s_rdy  <= (state_n == DECOUPLED) | (occ_n != 2'd2);
      ack    <= (state_n == DECOUPLED) & (occ_n == 2'd0);
      h_vld  <= (occ_n != 2'd0);
      k_vld  <= (occ_n == 2'd2);
    end
  end

  // Head register drives M; the skid entry only fills when the head is stalled.
  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      h_dat  <= '0;
      h_keep <= '0;
      h_last <= 1'b0;
      k_dat  <= '0;
      k_keep <= '0;
      k_last <= 1'b0;
    end else if (m_hs) begin
      if (k_vld) begin
        h_dat  <= k_dat;
        h_keep <= k_keep;
        h_last <= k_last;
        if (wr) begin
          k_dat  <= S_AXIS_tdata;
          k_keep <= S_AXIS_tkeep;
          k_last <= S_AXIS_tlast;
        end
      end else if (wr) begin
        h_dat  <= S_AXIS_tdata;
        h_keep <= S_AXIS_tkeep;
        h_last <= S_AXIS_tlast;
      end
    end else if (wr) begin
      if (h_vld) begin
        k_dat  <= S_AXIS_tdata;
        k_keep <= S_AXIS_tkeep;
        k_last <= S_AXIS_tlast;
      end else begin
        h_dat  <= S_AXIS_tdata;
        h_keep <= S_AXIS_tkeep;
        h_last <= S_AXIS_tlast;
      end
    end
  end

`ifdef PR_INGRESS_GATE_STATS_EN
  logic [CNT_WIDTH-1:0] pkt_q, drop_q;

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pkt_q  <= '0;
      drop_q <= '0;
    end else begin
      if (m_hs && h_last) pkt_q <= pkt_q + CNT_WIDTH'(1);
      if (s_acc && S_AXIS_tlast && (state == DECOUPLED)) drop_q <= drop_q + CNT_WIDTH'(1);
    end
  end

  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;
`else
  assign pkt_count  = '0;
  assign drop_count = '0;
`endif

  assign S_AXIS_tready = s_rdy;
  assign decouple_ack  = ack;
  assign M_AXIS_tvalid = h_vld;
  assign M_AXIS_tdata  = h_dat;
  assign M_AXIS_tkeep  = h_keep;
  assign M_AXIS_tlast  = h_last;

endmodule
